// File: rtl/pc_run_ctrl.sv
// Run-control sequencer for the program counter: loads an entry address on go, forwards
// decoder branches while running, and freezes the PC (self-branch) when stalled, idle or stopped.
module pc_run_ctrl #(
  parameter int INSTR_WIDTH = 9,
  parameter int CNT_WIDTH   = 16,
  parameter int MAX_CYCLES  = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go,
  input  logic [INSTR_WIDTH-1:0] start_addr,
  input  logic [INSTR_WIDTH-1:0] pc_in,
  input  logic                   halt,
  input  logic                   stall,
  input  logic                   br_req,
  input  logic                   br_taken,
  input  logic [INSTR_WIDTH-1:0] br_target,
  output logic                   pc_start,
  output logic [INSTR_WIDTH-1:0] pc_start_addr,
  output logic                   pc_branch,
  output logic                   pc_taken,
  output logic [INSTR_WIDTH-1:0] pc_target,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [CNT_WIDTH-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(MAX_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   budget_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign budget_hit = (cnt_q == LAST_CYCLE);

  // The PC has no enable, so every non-advancing cycle is a taken branch to pc_in.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    pc_start  = 1'b0;
    pc_branch = 1'b1;
    pc_taken  = 1'b1;
    pc_target = pc_in;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d   = S_LOAD;
          addr_d    = start_addr;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end

      S_LOAD: begin
        pc_start  = 1'b1;
        pc_branch = 1'b0;
        pc_taken  = 1'b0;
        state_d   = S_RUN;
      end

      S_RUN: begin
        // Counter saturates on the budget cycle so it never wraps.
        if (!budget_hit) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (halt) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (budget_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (!stall) begin
          pc_branch = br_req;
          pc_taken  = br_taken;
          pc_target = br_target;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign pc_start_addr = addr_q;
  assign busy          = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign timeout       = timeout_q;
  assign cycle_count   = cnt_q;

endmodule

// File: tb/tb_pc_run_ctrl.sv
// Self-checking bench for pc_run_ctrl: a behavioural PC closes the loop, and a program-level
// reference model predicts the controller outputs cycle by cycle under directed and random stimulus.
module tb_pc_run_ctrl;

  localparam int IW   = 9;
  localparam int CW   = 16;
  localparam int MAXC = 8;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          go = 1'b0, halt = 1'b0, stall = 1'b0, br_req = 1'b0, br_taken = 1'b0;
  logic [IW-1:0] start_addr = '0, br_target = '0;
  logic [IW-1:0] pc = '0;

  logic          pc_start, pc_branch, pc_taken, busy, done, timeout;
  logic [IW-1:0] pc_start_addr, pc_target;
  logic [CW-1:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: program phase, entry address, RUN cycles elapsed (unbounded), timeout flag.
  int            m_mode = M_IDLE;
  logic [IW-1:0] m_addr = '0;
  logic [IW-1:0] m_pc   = '0;
  int            m_run  = 0;
  logic          m_to   = 1'b0;

  logic          obs_start, obs_branch, obs_taken;
  logic [IW-1:0] obs_target;
  logic          exp_start, exp_branch, exp_taken;
  logic [IW-1:0] exp_target;

  pc_run_ctrl #(
    .INSTR_WIDTH(IW),
    .CNT_WIDTH  (CW),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .start_addr   (start_addr),
    .pc_in        (pc),
    .halt         (halt),
    .stall        (stall),
    .br_req       (br_req),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .pc_start     (pc_start),
    .pc_start_addr(pc_start_addr),
    .pc_branch    (pc_branch),
    .pc_taken     (pc_taken),
    .pc_target    (pc_target),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Behavioural PC: start has priority, then taken branch, else increment.
  always_ff @(posedge clk) begin
    if (pc_start)                   pc <= pc_start_addr;
    else if (pc_branch && pc_taken) pc <= pc_target;
    else                            pc <= pc + 1'b1;
  end

  function automatic logic [CW-1:0] exp_count();
    return CW'((m_run < MAXC - 1) ? m_run : MAXC - 1);
  endfunction

  function automatic logic exp_busy();
    return (m_mode == M_LOAD) || (m_mode == M_RUN);
  endfunction

  // One clock: drive at negedge, capture combinational outputs, advance model at posedge.
  task automatic step(input logic g, input logic [IW-1:0] a, input logic h, input logic s,
                      input logic b, input logic t, input logic [IW-1:0] tg);
    logic expire;
    @(negedge clk);
    go = g; start_addr = a; halt = h; stall = s; br_req = b; br_taken = t; br_target = tg;
    #1;
    obs_start  = pc_start;
    obs_branch = pc_branch;
    obs_taken  = pc_taken;
    obs_target = pc_target;
    expire     = (m_run == MAXC - 1);
    exp_start  = 1'b0;
    exp_branch = 1'b1;
    exp_taken  = 1'b1;
    exp_target = m_pc;
    if (m_mode == M_LOAD) begin
      exp_start  = 1'b1;
      exp_branch = 1'b0;
      exp_taken  = 1'b0;
    end else if (m_mode == M_RUN && !h && !expire && !s) begin
      exp_branch = b;
      exp_taken  = t;
      exp_target = tg;
    end
    @(posedge clk);
    if (exp_start)                    m_pc = m_addr;
    else if (exp_branch && exp_taken) m_pc = exp_target;
    else                              m_pc = m_pc + 1'b1;
    case (m_mode)
      M_IDLE, M_DONE: if (g) begin
        m_mode = M_LOAD; m_addr = a; m_run = 0; m_to = 1'b0;
      end
      M_LOAD: m_mode = M_RUN;
      default: begin
        if (h) begin
          m_mode = M_DONE; m_to = 1'b0;
        end else if (expire) begin
          m_mode = M_DONE; m_to = 1'b1;
        end
        m_run = m_run + 1;
      end
    endcase
    #1;
  endtask

  // Asynchronous reset asserted between edges; the PC itself keeps its value.
  task automatic do_reset();
    @(negedge clk);
    go = 0; halt = 0; stall = 0; br_req = 0; br_taken = 0; start_addr = '0; br_target = '0;
    #2 rst_n = 1'b0;
    #1;
    m_mode = M_IDLE; m_addr = '0; m_run = 0; m_to = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if ({pc_start, busy, done, timeout} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {pc_start, busy, done, timeout});
    end
    n_checks++;
    if (cycle_count !== '0 || pc_start_addr !== '0) begin
      n_fail++; $display("FAIL reset_regs: got count=%0d addr=%h expected 0 and 000", cycle_count, pc_start_addr);
    end
    n_checks++;
    if ({pc_branch, pc_taken, pc_target} !== {2'b11, pc}) begin
      n_fail++; $display("FAIL reset_hold: got %b %b %h expected 1 1 %h", pc_branch, pc_taken, pc_target, pc);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start_halt();
    step(1, 9'h010, 0, 0, 0, 0, '0);
    n_checks++;
    if (obs_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL go_accept: got start=%b busy=%b expected 0 1", obs_start, busy);
    end
    step(0, '0, 0, 0, 0, 0, '0);
    n_checks++;
    if ({obs_start, obs_branch} !== 2'b10) begin
      n_fail++; $display("FAIL load_pulse: got start=%b branch=%b expected 1 0", obs_start, obs_branch);
    end
    n_checks++;
    if (pc !== 9'h010 || cycle_count !== 16'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL run_entry: got pc=%h count=%0d busy=%b expected 010 0 1", pc, cycle_count, busy);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, '0, (m_pc == 9'h015), 0, 0, 0, '0);
      n_checks++;
      if (obs_start !== 1'b0) begin
        n_fail++; $display("FAIL start_once: got %b expected 0 at run cycle %0d", obs_start, i);
      end
    end
    n_checks++;
    if ({done, timeout, busy} !== 3'b100 || cycle_count !== 16'd6 || pc !== 9'h015) begin
      n_fail++; $display("FAIL halt_stop: got done/to/busy=%b count=%0d pc=%h expected 100 6 015",
                         {done, timeout, busy}, cycle_count, pc);
    end
    step(0, '0, 0, 0, 0, 0, '0);
    n_checks++;
    if (pc !== 9'h015 || cycle_count !== 16'd6) begin
      n_fail++; $display("FAIL done_hold: got pc=%h count=%0d expected 015 6", pc, cycle_count);
    end
  endtask

  task automatic test_stall_branch();
    step(1, 9'h020, 0, 0, 0, 0, '0);
    step(0, '0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 2; i++) begin
      step(0, '0, 0, 1, 1, 1, 9'h100);
      n_checks++;
      if (pc !== 9'h020) begin
        n_fail++; $display("FAIL stall_hold: got pc=%h expected 020 at stall %0d", pc, i);
      end
    end
    step(0, '0, 0, 0, 1, 1, 9'h100);
    n_checks++;
    if (pc !== 9'h100) begin
      n_fail++; $display("FAIL branch_taken: got pc=%h expected 100", pc);
    end
    step(0, '0, 1, 0, 0, 0, '0);
    n_checks++;
    if (done !== 1'b1 || timeout !== 1'b0 || cycle_count !== 16'd4) begin
      n_fail++; $display("FAIL stall_count: got done=%b to=%b count=%0d expected 1 0 4", done, timeout, cycle_count);
    end
  endtask

  task automatic test_budget();
    step(1, 9'h030, 0, 0, 0, 0, '0);
    step(0, '0, 0, 0, 0, 0, '0);
    for (int i = 0; i < MAXC; i++) begin
      step(0, '0, 0, 0, 1, 1, m_pc);
      if (i < MAXC - 1) begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL budget_early: got done=%b busy=%b expected 0 1 after cycle %0d", done, busy, i);
        end
      end
    end
    n_checks++;
    if ({done, timeout} !== 2'b11 || cycle_count !== CW'(MAXC - 1) || pc !== 9'h030) begin
      n_fail++; $display("FAIL budget_stop: got done/to=%b count=%0d pc=%h expected 11 %0d 030",
                         {done, timeout}, cycle_count, pc, MAXC - 1);
    end
  endtask

  task automatic test_halt_on_expiry();
    step(1, 9'h040, 0, 0, 0, 0, '0);
    step(0, '0, 0, 0, 0, 0, '0);
    for (int i = 0; i < MAXC; i++) begin
      step(1, IW'($urandom), (i == MAXC - 1), 0, 0, 0, '0);
      n_checks++;
      if (obs_start !== 1'b0) begin
        n_fail++; $display("FAIL go_in_run: got start=%b expected 0 at cycle %0d", obs_start, i);
      end
    end
    n_checks++;
    if ({done, timeout} !== 2'b10 || cycle_count !== CW'(MAXC - 1)) begin
      n_fail++; $display("FAIL halt_wins: got done/to=%b count=%0d expected 10 %0d", {done, timeout}, cycle_count, MAXC - 1);
    end
    n_checks++;
    if (pc_start_addr !== 9'h040 || pc !== 9'h047) begin
      n_fail++; $display("FAIL go_ignored: got addr=%h pc=%h expected 040 047", pc_start_addr, pc);
    end
  endtask

  task automatic test_reset_mid_run();
    step(1, 9'h050, 0, 0, 0, 0, '0);
    step(0, '0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, 0, '0);
    do_reset();
    n_checks++;
    if ({busy, done, timeout} !== 3'b000 || cycle_count !== '0 || pc_start_addr !== '0) begin
      n_fail++; $display("FAIL mid_reset: got b/d/t=%b count=%0d addr=%h expected 000 0 000",
                         {busy, done, timeout}, cycle_count, pc_start_addr);
    end
    step(0, '0, 0, 0, 0, 0, '0);
    step(0, '0, 0, 0, 0, 0, '0);
    n_checks++;
    if (pc !== 9'h053) begin
      n_fail++; $display("FAIL reset_pc_hold: got pc=%h expected 053", pc);
    end
    step(1, 9'h060, 0, 0, 0, 0, '0);
    step(0, '0, 0, 0, 0, 0, '0);
    step(0, '0, 1, 0, 0, 0, '0);
    step(1, 9'h070, 0, 0, 0, 0, '0);
    n_checks++;
    if (busy !== 1'b1 || cycle_count !== '0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL restart_accept: got busy=%b count=%0d to=%b expected 1 0 0", busy, cycle_count, timeout);
    end
    step(0, '0, 0, 0, 0, 0, '0);
    n_checks++;
    if (obs_start !== 1'b1 || pc !== 9'h070) begin
      n_fail++; $display("FAIL restart_load: got start=%b pc=%h expected 1 070", obs_start, pc);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 9; i++) begin
      step(1, IW'(9'h080 + i), 1, 0, 0, 0, '0);
      n_checks++;
      if ({obs_start, busy, done} !== {exp_start, exp_busy(), m_mode == M_DONE} ||
          pc_start_addr !== m_addr) begin
        n_fail++; $display("FAIL back_to_back: got start/busy/done=%b addr=%h expected %b %h", {obs_start, busy, done},
                           pc_start_addr, {exp_start, exp_busy(), m_mode == M_DONE}, m_addr);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(3) == 0), IW'($urandom), ($urandom_range(7) == 0), ($urandom_range(3) == 0),
             1'($urandom), 1'($urandom), IW'($urandom));
        n_checks++;
        if ({obs_start, obs_branch, obs_taken, obs_target} !== {exp_start, exp_branch, exp_taken, exp_target}) begin
          n_fail++; $display("FAIL rand_pc_ctrl: got %b%b%b %h expected %b%b%b %h at step %0d",
                             obs_start, obs_branch, obs_taken, obs_target, exp_start, exp_branch, exp_taken, exp_target, i);
        end
        n_checks++;
        if (obs_start && obs_branch) begin
          n_fail++; $display("FAIL rand_exclusive: got start=1 branch=1 expected never both at step %0d", i);
        end
      end
      n_checks++;
      if ({busy, done, timeout} !== {exp_busy(), m_mode == M_DONE, m_to}) begin
        n_fail++; $display("FAIL rand_status: got %b expected %b at step %0d", {busy, done, timeout},
                           {exp_busy(), m_mode == M_DONE, m_to}, i);
      end
      n_checks++;
      if (cycle_count !== exp_count() || pc_start_addr !== m_addr || pc !== m_pc) begin
        n_fail++; $display("FAIL rand_regs: got count=%0d addr=%h pc=%h expected %0d %h %h at step %0d",
                           cycle_count, pc_start_addr, pc, exp_count(), m_addr, m_pc, i);
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    test_reset();
    test_start_halt();
    test_stall_branch();
    test_budget();
    test_halt_on_expiry();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
